axi_xlate_requester: RTL
========================

Name: axi_xlate_requester

Overview:
- Initiator-side front end for the MMU translation path; one instance per AXI address channel (AR or AW).
- Accepts an upstream AXI-style address beat and holds it.
- Issues a virtual-address translation request to the translator, waits for its done strobe, then presents the translated physical address downstream with the original len/size.
- Enforces a translation timeout; a timed-out request is forwarded with a fault flag.

Parameters:
ADDR_W, 32, address width of upstream, translator and downstream address buses
TIMEOUT, 64, WAIT-state cycles before a translation is declared faulted (must be >= 2; translator nominal latency is ~42 cycles)
CNT_W, 16, width of completed-translation counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  upstream address valid
s_ready  out  1  upstream address ready
s_addr  in  ADDR_W  upstream virtual address
s_len  in  8  AXI burst length
s_size  in  3  AXI burst size
v_addr  out  ADDR_W  virtual address to translator
v_req  out  1  one-cycle translation request strobe
p_addr  in  ADDR_W  physical address from translator
t_done  in  1  translator done strobe; p_addr valid in the same cycle
m_valid  out  1  downstream address valid
m_ready  in  1  downstream address ready
m_addr  out  ADDR_W  translated (or faulted) address
m_len  out  8  captured s_len
m_size  out  3  captured s_size
m_fault  out  1  qualifies m_valid; 1 = translation timed out
busy  out  1  high in any state other than IDLE
xlate_cnt  out  CNT_W  count of non-faulted downstream handshakes, saturating
fault_cnt  out  8  count of faulted downstream handshakes, saturating

Behaviour:
- Reset (clk edge with reset=1): FSM->IDLE, timer=0.
  - During reset: s_ready=0, v_req=0, m_valid=0, m_fault=0, busy=0.
  - v_addr, m_addr, m_len, m_size, xlate_cnt, fault_cnt all cleared to 0.
  - Reset mid-operation drops the in-flight request; no downstream beat is produced.
- States: IDLE, REQ, WAIT, ISSUE.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: capture s_addr into v_addr and an internal vaddr reg; capture s_len->m_len, s_size->m_size; go REQ.
- REQ (exactly one cycle):
  - v_req=1, timer<=0; go WAIT.
  - v_addr is held stable from the capture edge until ISSUE is left.
- WAIT:
  - timer increments each cycle.
  - If t_done: m_addr<=p_addr, m_fault<=0, go ISSUE.
  - Else if timer==TIMEOUT-1: m_addr<=captured vaddr, m_fault<=1, go ISSUE.
  - t_done in the timeout cycle: done wins, no fault.
- ISSUE:
  - m_valid=1; m_addr, m_len, m_size and m_fault are held stable until handshake.
  - On m_ready: go IDLE. xlate_cnt+1 if m_fault=0, else fault_cnt+1; each counter saturates at its all-ones value.
  - m_fault is cleared on the transition to IDLE.
- s_ready=0 in REQ, WAIT and ISSUE (one outstanding request). s_valid outside IDLE is not accepted.
- t_done outside WAIT is ignored (stale or late response); no state or output change.
- Latency:
  - Handshake edge = cycle 0; v_req high in cycle 1.
  - t_done sampled in cycle N -> m_valid high in cycle N+1.
  - Minimum: t_done in cycle 2 -> m_valid in cycle 3.
  - Back-to-back: next s_ready one cycle after the m handshake.
- Timeout: with no t_done, m_valid rises TIMEOUT+2 cycles after the s handshake.
- Width: m_addr = p_addr verbatim. No arithmetic on addresses; the timer is wide enough for TIMEOUT.

Test Plan:
- Nominal: translator model with +0x1000 offset and 40-cycle delay, s_addr=0x0000_2000, len=3, size=2 -> one v_req pulse with v_addr=0x2000; m_valid with m_addr=0x3000, m_len=3, m_size=2, m_fault=0; xlate_cnt=1.
- Backpressure: m_ready held low 10 cycles after m_valid -> m_addr, m_len, m_size, m_fault stable; s_ready stays 0; a second s_valid is not accepted until one cycle after the m handshake.
- Timeout: t_done never asserted, TIMEOUT=64, s_addr=0x4000 -> m_valid exactly 66 cycles after the s handshake with m_addr=0x4000, m_fault=1; fault_cnt=1, xlate_cnt unchanged.
- Race: t_done asserted in the same cycle timer==TIMEOUT-1 -> m_fault=0, m_addr=p_addr. Separately, spurious t_done in IDLE -> no output change.
- Reset mid-WAIT: reset=1 for one cycle at cycle 20 -> no m_valid; all outputs 0; after release, s_ready=1 and a new request completes normally.
- Saturation: CNT_W=2, five nominal transactions -> xlate_cnt sticks at 3.

Source files
------------

// File: rtl/axi_xlate_requester.sv
// rtl/axi_xlate_requester.sv - address-channel front end: capture, translate with timeout, reissue downstream
module axi_xlate_requester #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [7:0]        s_len,
    input  logic [2:0]        s_size,
    output logic [ADDR_W-1:0] v_addr,
    output logic              v_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              t_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_len,
    output logic [2:0]        m_size,
    output logic              m_fault,
    output logic              busy,
    output logic [CNT_W-1:0]  xlate_cnt,
    output logic [7:0]        fault_cnt
);

    // Timer only has to reach TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] vaddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            s_ready   <= 1'b0;
            v_req     <= 1'b0;
            m_valid   <= 1'b0;
            m_fault   <= 1'b0;
            busy      <= 1'b0;
            v_addr    <= '0;
            vaddr_q   <= '0;
            m_addr    <= '0;
            m_len     <= '0;
            m_size    <= '0;
            xlate_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        v_addr  <= s_addr;
                        vaddr_q <= s_addr;
                        m_len   <= s_len;
                        m_size  <= s_size;
                        s_ready <= 1'b0;
                        v_req   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    v_req <= 1'b0;
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A done strobe in the final timer cycle still counts as success.
                    if (t_done) begin
                        m_addr  <= p_addr;
                        m_fault <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= ISSUE;
                    end else if (timer == TMR_LAST) begin
                        m_addr  <= vaddr_q;
                        m_fault <= 1'b1;
                        m_valid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        if (m_fault) begin
                            if (fault_cnt != '1)
                                fault_cnt <= fault_cnt + 1'b1;
                        end else begin
                            if (xlate_cnt != '1)
                                xlate_cnt <= xlate_cnt + 1'b1;
                        end
                        m_valid <= 1'b0;
                        m_fault <= 1'b0;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
